// File: rtl/display_source_mux.sv
// display_source_mux: registered N-way display source selector with blanked, glitch-free switching.
// Ports: clk, rst_n (async active-low); sel_req/req_valid request a source; seg_in/an_in carry the
// flattened per-source buses; auto_en enables auto-rotate; segments/anodes are the registered pin
// outputs; active_sel is the committed source; busy flags a switch in progress.
// Optional feature: define DISPLAY_SRC_AUTOCYCLE_EN to build the auto-rotate timer.
module display_source_mux #(
  parameter int NUM_SRC = 2,
  parameter int SEG_W = 7,
  parameter int AN_W = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int AUTO_PERIOD = 100000000,
  parameter int SEL_W = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel_req,
  input  logic                     req_valid,
  input  logic [NUM_SRC*SEG_W-1:0] seg_in,
  input  logic [NUM_SRC*AN_W-1:0]  an_in,
  input  logic                     auto_en,
  output logic [SEG_W-1:0]         segments,
  output logic [AN_W-1:0]          anodes,
  output logic [SEL_W-1:0]         active_sel,
  output logic                     busy
);
  localparam int CNT_W = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [SEL_W:0] SRC_N = (SEL_W+1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
  typedef enum logic {RUN, BLANK} state_t;
  state_t state, state_nx;
  logic [SEL_W-1:0] pending, pending_nx, active_nx, out_sel, next_src;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEG_W-1:0] seg_nx;
  logic [AN_W-1:0] an_nx;
  logic ext_ok, tick, accept, show;
  assign ext_ok = req_valid && {1'b0, sel_req} < SRC_N && sel_req != active_sel;
  assign next_src = active_sel == SEL_LAST ? '0 : active_sel + 1'b1;
`ifdef DISPLAY_SRC_AUTOCYCLE_EN
  localparam int ACNT_W = $clog2(AUTO_PERIOD + 1);
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(AUTO_PERIOD - 1);
  logic [ACNT_W-1:0] acnt;
  assign tick = state == RUN && auto_en && acnt == ACNT_LAST;
  // Clears on any accepted switch, when disabled, and for the whole blank including the commit edge.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acnt <= '0;
    else acnt <= state == RUN && auto_en && !accept ? acnt + 1'b1 : '0;
`else
  logic unused_auto;
  assign unused_auto = auto_en | (AUTO_PERIOD == 0);
  assign tick = 1'b0;
`endif
  // An external request beats a coincident auto tick.
  assign accept = state == RUN && (ext_ok || tick);
  // On the commit edge the outputs already take the pending source.
  assign out_sel = state == BLANK ? pending : active_sel;
  assign show = !accept && (state == RUN || cnt == '0);
  assign seg_nx = show ? seg_in[int'(out_sel)*SEG_W +: SEG_W] : '1;
  assign an_nx = show ? an_in[int'(out_sel)*AN_W +: AN_W] : '1;
  always_comb begin
    state_nx = state;
    pending_nx = pending;
    active_nx = active_sel;
    cnt_nx = cnt;
    if (state == RUN) begin
      if (accept) begin
        state_nx = BLANK;
        pending_nx = ext_ok ? sel_req : next_src;
        cnt_nx = CNT_LOAD;
      end
    end else if (cnt == '0) begin
      state_nx = RUN;
      active_nx = pending;
    end else begin
      cnt_nx = cnt - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      active_sel <= '0;
      pending <= '0;
      cnt <= '0;
      segments <= '1;
      anodes <= '1;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      active_sel <= active_nx;
      pending <= pending_nx;
      cnt <= cnt_nx;
      segments <= seg_nx;
      anodes <= an_nx;
      busy <= state_nx == BLANK;
    end
endmodule

// File: tb/tb_display_source_mux.sv
// tb_display_source_mux: directed bench with a behavioural reference model for display_source_mux.
module tb_display_source_mux;
  localparam int N = 3;
  localparam int BLANK = 3;
  localparam int PERIOD = 5;
`ifdef DISPLAY_SRC_AUTOCYCLE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] sel_req = '0;
  logic req_valid = 1'b0;
  logic [N*7-1:0] seg_in;
  logic [N*8-1:0] an_in;
  logic auto_en = 1'b0;
  logic [6:0] segments;
  logic [7:0] anodes;
  logic [1:0] active_sel;
  logic busy;
  int checks = 0;
  int fails = 0;
  bit chk_on = 1'b0;
  always #5 clk = ~clk;
  display_source_mux #(.NUM_SRC(N), .SEG_W(7), .AN_W(8), .BLANK_CYCLES(BLANK), .AUTO_PERIOD(PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .req_valid(req_valid), .seg_in(seg_in),
    .an_in(an_in), .auto_en(auto_en), .segments(segments), .anodes(anodes),
    .active_sel(active_sel), .busy(busy));
  // Model: which source is on the pins, how many blank cycles remain, how long the source has shown.
  typedef struct {
    int act;
    int pend;
    int left;
    int run;
    bit blank;
    logic [6:0] seg;
    logic [7:0] an;
  } mst_t;
  mst_t m;
  function automatic mst_t step(mst_t s, logic rv, logic [1:0] sr, logic ae,
                                logic [N*7-1:0] si, logic [N*8-1:0] ai);
    mst_t n = s;
    bit ext = rv && sr < N && int'(sr) != s.act;
    bit tk = AUTO && ae && !s.blank && s.run == PERIOD - 1;
    if (s.blank) begin
      n.run = 0;
      if (s.left == 0) begin
        n.blank = 1'b0;
        n.act = s.pend;
      end else n.left = s.left - 1;
    end else if (ext || tk) begin
      n.pend = ext ? int'(sr) : (s.act + 1) % N;
      n.blank = 1'b1;
      n.left = BLANK - 1;
      n.run = 0;
    end else n.run = ae ? s.run + 1 : 0;
    n.seg = n.blank ? 7'h7F : si[n.act*7 +: 7];
    n.an = n.blank ? 8'hFF : ai[n.act*8 +: 8];
    return n;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= '{act: 0, pend: 0, left: 0, run: 0, blank: 1'b0, seg: 7'h7F, an: 8'hFF};
    else m <= step(m, req_valid, sel_req, auto_en, seg_in, an_in);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_on) begin
      chk("model segments", 32'(segments), 32'(m.seg));
      chk("model anodes", 32'(anodes), 32'(m.an));
      chk("model active_sel", 32'(active_sel), 32'(m.act));
      chk("model busy", 32'(busy), 32'(m.blank));
    end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic req(input logic [1:0] s);
    sel_req = s;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  initial begin
    logic [6:0] v;
    seg_in = {7'h24, 7'h12, 7'h01};
    an_in = {8'hFB, 8'hFD, 8'hFE};
    cyc(2);
    chk_on = 1'b1;
    chk("reset segments", 32'(segments), 32'h7F);
    chk("reset busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    cyc(1);
    chk("first src0 seg", 32'(segments), 32'h01);
    chk("first src0 an", 32'(anodes), 32'hFE);
    req(2'd0);
    chk("same-source ignored", 32'(busy), 32'h0);
    req(2'd3);
    chk("out-of-range ignored", 32'(busy), 32'h0);
    req(2'd2);
    chk("blank1 seg", 32'(segments), 32'h7F);
    chk("blank1 busy", 32'(busy), 32'h1);
    req(2'd1);
    chk("blank2 seg", 32'(segments), 32'h7F);
    cyc(1);
    chk("blank3 an", 32'(anodes), 32'hFF);
    chk("blank3 busy", 32'(busy), 32'h1);
    cyc(1);
    chk("commit seg", 32'(segments), 32'h24);
    chk("commit an", 32'(anodes), 32'hFB);
    chk("commit active", 32'(active_sel), 32'h2);
    chk("commit busy", 32'(busy), 32'h0);
    req(2'd1);
    cyc(3);
    chk("switch to 1", 32'(active_sel), 32'h1);
    for (int i = 0; i < 6; i++) begin
      v = 7'($urandom);
      seg_in[7 +: 7] = v;
      cyc(1);
      chk("passthrough", 32'(segments), 32'(v));
    end
    req(2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst seg", 32'(segments), 32'h7F);
    chk("async rst an", 32'(anodes), 32'hFF);
    chk("async rst active", 32'(active_sel), 32'h0);
    chk("async rst busy", 32'(busy), 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("post-rst src0", 32'(segments), 32'h01);
    auto_en = 1'b1;
`ifdef DISPLAY_SRC_AUTOCYCLE_EN
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(4);
    req(2'd2);
    chk("tick override busy", 32'(busy), 32'h1);
    cyc(3);
    chk("override active", 32'(active_sel), 32'h2);
    cyc(5);
    chk("auto tick busy", 32'(busy), 32'h1);
    cyc(3);
    chk("auto wrap to 0", 32'(active_sel), 32'h0);
    cyc(8);
    chk("auto to 1", 32'(active_sel), 32'h1);
    cyc(8);
    chk("auto to 2", 32'(active_sel), 32'h2);
    cyc(8);
    chk("auto back to 0", 32'(active_sel), 32'h0);
`else
    cyc(1000);
    chk("no autocycle", 32'(active_sel), 32'h0);
    chk("no autocycle busy", 32'(busy), 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
